// File: rtl/connect4_pkg.sv
// Shared Connect Four board geometry plus index helpers for the board engine and the win detector.
package connect4_pkg;
  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELL  = 16;
  localparam int X0    = 24;
  localparam int Y0    = 16;
  localparam int NCELL = COLS * ROWS;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } col_sel_t;

  function automatic logic [5:0] cell_idx(input int col, input int row);
    return 6'(col * ROWS + row);
  endfunction

  // valid only when exactly one bit is set; idx then names that column
  function automatic col_sel_t onehot_to_idx(input logic [COLS-1:0] v);
    col_sel_t s;
    int n;
    s = '0;
    n = 0;
    for (int i = 0; i < COLS; i++) begin
      if (v[i]) begin
        n++;
        s.idx = 3'(i);
      end
    end
    s.valid = (n == 1);
    return s;
  endfunction
endpackage

// File: rtl/four_in_row_detect.sv
// Flags any four contiguous occupied cells (horizontal, vertical, both diagonals) in one colour's map.
module four_in_row_detect
  import connect4_pkg::*;
(
  input  logic [NCELL-1:0] i_map,
  output logic             o_win
);

  function automatic logic at(input logic [NCELL-1:0] m, input int c, input int r);
    return m[cell_idx(c, r)];
  endfunction

  always_comb begin
    o_win = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (c + 3 < COLS &&
            at(i_map, c, r) && at(i_map, c + 1, r) && at(i_map, c + 2, r) && at(i_map, c + 3, r))
          o_win = 1'b1;
        if (r + 3 < ROWS &&
            at(i_map, c, r) && at(i_map, c, r + 1) && at(i_map, c, r + 2) && at(i_map, c, r + 3))
          o_win = 1'b1;
        if (c + 3 < COLS && r + 3 < ROWS &&
            at(i_map, c, r) && at(i_map, c + 1, r + 1) &&
            at(i_map, c + 2, r + 2) && at(i_map, c + 3, r + 3))
          o_win = 1'b1;
        if (c + 3 < COLS && r >= 3 &&
            at(i_map, c, r) && at(i_map, c + 1, r - 1) &&
            at(i_map, c + 2, r - 2) && at(i_map, c + 3, r - 3))
          o_win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_state_engine.sv
// Connect Four board: stacks strobed drops, latches draw origin, counts pieces, tracks sticky wins.
module board_state_engine
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic [COLS-1:0]  load_r,
  input  logic [COLS-1:0]  load_b,
  input  logic [COLS-1:0]  load_c,
  input  logic             checkr,
  input  logic             checkb,
  output logic [7:0]       draw_x,
  output logic [6:0]       draw_y,
  output logic [NCELL-1:0] red_map,
  output logic [NCELL-1:0] blue_map,
  output logic [COLS-1:0]  col_full,
  output logic [5:0]       boardcounter,
  output logic             rwin,
  output logic             bwin,
  output logic             win,
  output logic             illegal
);

  logic [2:0]       r_height [COLS];
  logic [NCELL-1:0] r_red_map;
  logic [NCELL-1:0] r_blue_map;
  logic [5:0]       r_count;
  logic [7:0]       r_draw_x;
  logic [6:0]       r_draw_y;
  logic             r_rwin;
  logic             r_bwin;
  logic             r_illegal;

  col_sel_t   w_r_sel, w_b_sel, w_c_sel;
  logic       w_r_any, w_b_any, w_bad_strobe, w_col_full, w_accept, w_reject;
  logic [2:0] w_col, w_c_row;
  logic       w_red_win, w_blue_win;

  assign w_r_sel = onehot_to_idx(load_r);
  assign w_b_sel = onehot_to_idx(load_b);
  assign w_c_sel = onehot_to_idx(load_c);
  assign w_r_any = |load_r;
  assign w_b_any = |load_b;

  // Malformed strobes are rejected before the column height is even considered
  assign w_bad_strobe = (w_r_any && w_b_any) ||
                        (w_r_any && !w_r_sel.valid) ||
                        (w_b_any && !w_b_sel.valid);
  assign w_col      = w_r_any ? w_r_sel.idx : w_b_sel.idx;
  assign w_col_full = (r_height[w_col] == 3'(ROWS));
  assign w_accept   = (w_r_any || w_b_any) && !w_bad_strobe && !w_col_full;
  assign w_reject   = (w_r_any || w_b_any) && !w_accept;

  // Coordinates use the pre-drop height: row of the topmost piece, or 0 when empty
  assign w_c_row = (r_height[w_c_sel.idx] == 3'd0) ? 3'd0 : r_height[w_c_sel.idx] - 3'd1;

  four_in_row_detect u_red_detect  (.i_map(r_red_map),  .o_win(w_red_win));
  four_in_row_detect u_blue_detect (.i_map(r_blue_map), .o_win(w_blue_win));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      for (int c = 0; c < COLS; c++) r_height[c] <= 3'd0;
      r_red_map  <= '0;
      r_blue_map <= '0;
      r_count    <= 6'd0;
      r_draw_x   <= 8'd0;
      r_draw_y   <= 7'd0;
      r_rwin     <= 1'b0;
      r_bwin     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_reject;
      if (w_accept) begin
        if (w_r_any) r_red_map[cell_idx(int'(w_col), int'(r_height[w_col]))]  <= 1'b1;
        else         r_blue_map[cell_idx(int'(w_col), int'(r_height[w_col]))] <= 1'b1;
        r_height[w_col] <= r_height[w_col] + 3'd1;
        if (r_count != 6'(NCELL)) r_count <= r_count + 6'd1;
      end
      if (w_c_sel.valid) begin
        r_draw_x <= 8'(X0 + int'(w_c_sel.idx) * CELL);
        r_draw_y <= 7'(Y0 + (ROWS - 1 - int'(w_c_row)) * CELL);
      end
      if (checkr) r_rwin <= r_rwin | w_red_win;
      if (checkb) r_bwin <= r_bwin | w_blue_win;
    end
  end

  always_comb begin
    col_full = '0;
    for (int c = 0; c < COLS; c++) col_full[c] = (r_height[c] == 3'(ROWS));
  end

  assign draw_x       = r_draw_x;
  assign draw_y       = r_draw_y;
  assign red_map      = r_red_map;
  assign blue_map     = r_blue_map;
  assign boardcounter = r_count;
  assign rwin         = r_rwin;
  assign bwin         = r_bwin;
  assign win          = r_rwin | r_bwin;
  assign illegal      = r_illegal;

endmodule
